// File: rtl/down_counter_timer.sv
// Loadable down-counting timer with valid/ready load and one-cycle done pulse on expiry.
// Define DOWN_COUNTER_TIMER_AUTO_RELOAD_EN for periodic mode (reload on expiry); default is one-shot.
module down_counter_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_value,
  output logic             load_ready,
  input  logic             en,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  // state | meaning
  // IDLE  | waiting for a load; load_ready high, count held at 0
  // RUN   | counting down on enabled cycles; busy high
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_valid) begin
          count_d  = load_value;
          reload_d = load_value;
          if (load_value != '0) state_d = RUN;
          else                  done_d  = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          count_d = '0;
        end else if (en) begin
          if (count_q > WIDTH'(1)) begin
            count_d = count_q - WIDTH'(1);
          end else begin
            // count of 1 expires; 0 cannot occur in RUN but is treated the same
            done_d = 1'b1;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
            count_d = reload_q;
`else
            count_d = '0;
            state_d = IDLE;
`endif
          end
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q == RUN);
  assign count      = count_q;
  assign done       = done_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer: directed scenarios plus randomized traffic
// against a model that tracks enabled cycles elapsed since the load.
module tb_down_counter_timer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_valid = 1'b0;
  logic [3:0] load_value = '0;
  logic       load_ready;
  logic       en = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] count;
  logic       busy;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  // model: a countdown of length m_n is in progress with m_k enabled cycles elapsed
  bit m_run  = 1'b0;
  int m_n    = 0;
  int m_k    = 0;
  bit m_done = 1'b0;

  down_counter_timer #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_value (load_value),
    .load_ready (load_ready),
    .en         (en),
    .abort      (abort),
    .count      (count),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_count();
    return m_run ? (m_n - m_k) : 0;
  endfunction

  task automatic model_edge(input bit lv, input int val, input bit e, input bit ab, input bit r);
    if (!r) begin
      m_run = 1'b0; m_n = 0; m_k = 0; m_done = 1'b0;
    end else if (!m_run) begin
      m_done = 1'b0;
      if (lv) begin
        m_n = val; m_k = 0;
        if (val != 0) m_run = 1'b1;
        else          m_done = 1'b1;
      end
    end else begin
      m_done = 1'b0;
      if (ab) begin
        m_run = 1'b0;
      end else if (e) begin
        m_k++;
        if (m_k == m_n) begin
          m_done = 1'b1;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
          m_k = 0;
`else
          m_run = 1'b0;
`endif
        end
      end
    end
  endtask

  task automatic step(input bit lv, input int val, input bit e, input bit ab, input bit r);
    load_valid = lv;
    load_value = 4'(val);
    en         = e;
    abort      = ab;
    rst_n      = r;
    model_edge(lv, val & 15, e, ab, r);
    @(posedge clk);
    #1;
    check_eq("count", int'(count), m_count());
    check_eq("done", int'(done), int'(m_done));
    check_eq("busy", int'(busy), int'(m_run));
    check_eq("load_ready", int'(load_ready), int'(!m_run));
  endtask

  initial begin
    int seq[6];
    int gen[5];

    // reset held two cycles
    step(0, 0, 0, 0, 0);
    step(1, 7, 1, 0, 0);
    check_eq("rst_count", int'(count), 0);
    check_eq("rst_ready", int'(load_ready), 1);
    step(0, 0, 0, 0, 1);

`ifndef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
    // one-shot load 5
    seq = '{5, 4, 3, 2, 1, 0};
    step(1, 5, 1, 0, 1);
    check_eq("os_seq", int'(count), seq[0]);
    for (int i = 1; i < 6; i++) begin
      step(0, 0, 1, 0, 1);
      check_eq("os_seq", int'(count), seq[i]);
      check_eq("os_done", int'(done), (i == 5) ? 1 : 0);
    end
    check_eq("os_ready_after", int'(load_ready), 1);

    // gated enable
    seq = '{3, 2, 2, 2, 1, 0};
    gen = '{1, 0, 0, 1, 1};
    step(1, 3, 0, 0, 1);
    check_eq("gate_seq", int'(count), seq[0]);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, gen[i] != 0, 0, 1);
      check_eq("gate_seq", int'(count), seq[i+1]);
      check_eq("gate_done", int'(done), (i == 4) ? 1 : 0);
    end

    // abort with ignored mid-run load
    step(1, 9, 1, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 2, 1, 0, 1);
    check_eq("abort_pre", int'(count), 6);
    step(0, 0, 1, 1, 1);
    check_eq("abort_count", int'(count), 0);
    check_eq("abort_busy", int'(busy), 0);
    check_eq("abort_done", int'(done), 0);

    // zero load then back-to-back load 2 in the done cycle
    step(1, 0, 1, 0, 1);
    check_eq("zero_done", int'(done), 1);
    check_eq("zero_busy", int'(busy), 0);
    step(1, 2, 1, 0, 1);
    check_eq("b2b_count", int'(count), 2);
    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 1);
    check_eq("b2b_done", int'(done), 1);
`else
    // periodic load 3
    seq = '{3, 2, 1, 3, 2, 1};
    step(1, 3, 1, 0, 1);
    check_eq("per_seq", int'(count), seq[0]);
    for (int i = 1; i < 6; i++) begin
      step(0, 0, 1, 0, 1);
      check_eq("per_seq", int'(count), seq[i]);
      check_eq("per_done", int'(done), (i == 3) ? 1 : 0);
    end
    step(0, 0, 1, 0, 0);
    check_eq("per_rst_count", int'(count), 0);
    check_eq("per_rst_busy", int'(busy), 0);
    step(0, 0, 0, 0, 1);
    step(1, 1, 1, 0, 1);
    step(0, 0, 1, 0, 1);
    check_eq("per_one_done", int'(done), 1);
    step(0, 0, 1, 0, 1);
    check_eq("per_one_done", int'(done), 1);
    step(0, 0, 1, 1, 1);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit lv, e, ab, r;
      int val;
      lv  = ($urandom_range(0, 3) != 0);
      val = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 15));
      e   = ($urandom_range(0, 3) != 0);
      ab  = ($urandom_range(0, 29) == 0);
      r   = ($urandom_range(0, 199) != 0);
      step(lv, val, e, ab, r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
